// File: rtl/sequence_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sequence_tx_pkg
//  Description : Shared definitions for the serial sequence generator:
//                2-bit state codes and the bit-counter width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package sequence_tx_pkg;

    typedef logic [1:0] state_t;

    // Codes are visible on the Q1/Q0 debug outputs; 2'b11 is illegal.
    localparam state_t IDLE  = 2'b00;
    localparam state_t SHIFT = 2'b01;
    localparam state_t DONE  = 2'b10;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sequence_tx_bit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sequence_tx_bit_counter
//  Description : Mod-N counter used to count bits within a frame.
//  Ports       : clock  - rising-edge clock
//                reset  - asynchronous active-high reset (count -> 0)
//                clear  - synchronous clear to 0 (priority over enable)
//                enable - advance count, wrapping N-1 -> 0
//                last   - high while the count equals N-1
//  Revision    : 1.0  initial release
// ============================================================================
module sequence_tx_bit_counter
    import sequence_tx_pkg::*;
#(
    parameter int N = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam int               CNT_W = cnt_w(N);
    localparam logic [CNT_W-1:0] TERM  = CNT_W'(N - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == TERM) ? '0 : cnt + 1'b1;
        end
    end

    assign last = (cnt == TERM);

endmodule
`default_nettype wire

// File: rtl/sequence_tx.sv
`default_nettype none
// ============================================================================
//  Module      : sequence_tx
//  Description : Serial sequence generator. Captures an N-bit pattern on an
//                accepted start and shifts it out MSB first on w, one bit per
//                clock, optionally resending it back-to-back.
//  Ports       : clock       - rising-edge clock
//                reset       - asynchronous active-high reset
//                start       - request a frame (sampled only in IDLE)
//                repeat_mode - resend captured pattern at end of frame
//                pattern     - N-bit pattern captured on accepted start
//                w           - serial data out, MSB first
//                busy        - high while a frame is shifting
//                done        - one-cycle pulse after a non-repeating run
//                Q1, Q0      - current state code for observation
//  Revision    : 1.0  initial release
// ============================================================================
module sequence_tx
    import sequence_tx_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         repeat_mode,
    input  logic [N-1:0] pattern,
    output logic         w,
    output logic         busy,
    output logic         done,
    output logic         Q1,
    output logic         Q0
);

    state_t       state;
    logic [N-1:0] sreg;
    logic [N-1:0] pcopy;
    logic         last;

    // Counter runs only while shifting; it wraps to 0 on its own at the
    // last bit, which is exactly what a repeated frame needs.
    sequence_tx_bit_counter #(
        .N      (N)
    ) u_bit_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (state != SHIFT),
        .enable (state == SHIFT),
        .last   (last)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sreg  <= '0;
            pcopy <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sreg  <= pattern;
                        pcopy <= pattern;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!last) begin
                        sreg <= {sreg[N-2:0], 1'b0};
                    end else if (repeat_mode) begin
                        // Reload from the captured copy, not the live input.
                        sreg <= pcopy;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state only, so they follow reset at once.
    assign w    = (state == SHIFT) & sreg[N-1];
    assign busy = (state == SHIFT);
    assign done = (state == DONE);
    assign Q1   = state[1];
    assign Q0   = state[0];

endmodule
`default_nettype wire
